// File: rtl/imm_gen_pipe_if.sv
// Flow-controlled bus for the immediate-generator stage: instruction in, immediate out.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    // Upstream/downstream environment view: drives instructions and out_ready.
    modport master (
        output in_valid, in_inst, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    // Stage view: accepts instructions and presents decoded immediates.
    modport slave (
        input  in_valid, in_inst, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RV immediate generator with a two-entry skid buffer so that
// in_ready comes straight from a flop.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input logic            clk,
    input logic            rst,
    input logic            flush,
    imm_gen_pipe_if.slave  bus
);
    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_SH   = 3'd6;
    localparam logic [2:0] FMT_NONE = 3'd7;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [XLEN-1:0]  m_imm_q, m_imm_d, s_imm_q, s_imm_d;
    logic [2:0]       m_fmt_q, m_fmt_d, s_fmt_q, s_fmt_d;
    logic             m_ill_q, m_ill_d, s_ill_q, s_ill_d;
    logic [TAG_W-1:0] m_tag_q, m_tag_d, s_tag_q, s_tag_d;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_fmt;
    logic             dec_ill;
    logic             accept;
    logic             pop;

    assign opcode = bus.in_inst[6:0];
    assign funct3 = bus.in_inst[14:12];

    // Decode the incoming word into an extended immediate, format code and illegal flag.
    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        case (opcode)
            7'b0000011, 7'b1100111, 7'b0001111: begin
                dec_imm = XLEN'($signed(bus.in_inst[31:20]));
                dec_fmt = FMT_I;
            end
            7'b0010011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    if (XLEN == 64) dec_imm = XLEN'(bus.in_inst[25:20]);
                    else            dec_imm = XLEN'(bus.in_inst[24:20]);
                    dec_fmt = FMT_SH;
                end else begin
                    dec_imm = XLEN'($signed(bus.in_inst[31:20]));
                    dec_fmt = FMT_I;
                end
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    if (funct3 == 3'b001 || funct3 == 3'b101) begin
                        dec_imm = XLEN'(bus.in_inst[24:20]);
                        dec_fmt = FMT_SH;
                    end else begin
                        dec_imm = XLEN'($signed(bus.in_inst[31:20]));
                        dec_fmt = FMT_I;
                    end
                end else begin
                    dec_ill = 1'b1;
                end
            end
            7'b1110011: begin
                dec_imm = XLEN'(bus.in_inst[31:20]);
                dec_fmt = FMT_I;
            end
            7'b0100011: begin
                dec_imm = XLEN'($signed({bus.in_inst[31:25], bus.in_inst[11:7]}));
                dec_fmt = FMT_S;
            end
            7'b1100011: begin
                dec_imm = XLEN'($signed({bus.in_inst[31], bus.in_inst[7],
                                         bus.in_inst[30:25], bus.in_inst[11:8], 1'b0}));
                dec_fmt = FMT_B;
            end
            7'b1101111: begin
                dec_imm = XLEN'($signed({bus.in_inst[31], bus.in_inst[19:12],
                                         bus.in_inst[20], bus.in_inst[30:21], 1'b0}));
                dec_fmt = FMT_J;
            end
            7'b0110111, 7'b0010111: begin
                dec_imm = XLEN'($signed({bus.in_inst[31:12], 12'b0}));
                dec_fmt = FMT_U;
            end
            7'b0110011: begin
                dec_fmt = FMT_R;
            end
            7'b0111011: begin
                if (XLEN == 64) dec_fmt = FMT_R;
                else            dec_ill = 1'b1;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
    end

    assign accept = bus.in_valid & in_ready_q;
    assign pop    = bus.out_valid & bus.out_ready;

    // Buffer control: move entries between main and skid registers; flush empties the stage.
    always_comb begin
        state_d = state_q;
        m_imm_d = m_imm_q;
        m_fmt_d = m_fmt_q;
        m_ill_d = m_ill_q;
        m_tag_d = m_tag_q;
        s_imm_d = s_imm_q;
        s_fmt_d = s_fmt_q;
        s_ill_d = s_ill_q;
        s_tag_d = s_tag_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        m_imm_d = dec_imm;
                        m_fmt_d = dec_fmt;
                        m_ill_d = dec_ill;
                        m_tag_d = bus.in_tag;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        m_imm_d = dec_imm;
                        m_fmt_d = dec_fmt;
                        m_ill_d = dec_ill;
                        m_tag_d = bus.in_tag;
                    end else if (accept) begin
                        state_d = TWO;
                        s_imm_d = dec_imm;
                        s_fmt_d = dec_fmt;
                        s_ill_d = dec_ill;
                        s_tag_d = bus.in_tag;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d = ONE;
                        m_imm_d = s_imm_q;
                        m_fmt_d = s_fmt_q;
                        m_ill_d = s_ill_q;
                        m_tag_d = s_tag_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        in_ready_d = (state_d != TWO);
    end

    // State, ready flop and buffer contents; reset puts the stage in a known idle state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            m_imm_q    <= '0;
            m_fmt_q    <= FMT_NONE;
            m_ill_q    <= 1'b0;
            m_tag_q    <= '0;
            s_imm_q    <= '0;
            s_fmt_q    <= '0;
            s_ill_q    <= 1'b0;
            s_tag_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            m_imm_q    <= m_imm_d;
            m_fmt_q    <= m_fmt_d;
            m_ill_q    <= m_ill_d;
            m_tag_q    <= m_tag_d;
            s_imm_q    <= s_imm_d;
            s_fmt_q    <= s_fmt_d;
            s_ill_q    <= s_ill_d;
            s_tag_q    <= s_tag_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = (state_q != EMPTY);
    assign bus.out_imm     = m_imm_q;
    assign bus.out_fmt     = m_fmt_q;
    assign bus.out_illegal = m_ill_q;
    assign bus.out_tag     = m_tag_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance share
// clock, reset, flush and stimulus; each has its own hand-computed expectations.
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (.clk(clk), .rst(rst), .flush(flush), .bus(bus32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (.clk(clk), .rst(rst), .flush(flush), .bus(bus64));

    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Drive the same upstream/downstream controls into both instances.
    task automatic apply_stimulus(input logic valid, input logic [31:0] inst,
                                  input logic [31:0] tag, input logic oready);
        bus32.in_valid  = valid;
        bus32.in_inst   = inst;
        bus32.in_tag    = tag;
        bus32.out_ready = oready;
        bus64.in_valid  = valid;
        bus64.in_inst   = inst;
        bus64.in_tag    = tag;
        bus64.out_ready = oready;
    endtask

    // Check the presented entry on both instances.
    task automatic check_both(input string name, input logic v, input logic [31:0] tag,
                              input logic [63:0] imm32, input logic [2:0] fmt32, input logic ill32,
                              input logic [63:0] imm64, input logic [2:0] fmt64, input logic ill64);
        check_output({name, ".v32"},   64'(bus32.out_valid),   64'(v));
        check_output({name, ".tag32"}, 64'(bus32.out_tag),     64'(tag));
        check_output({name, ".imm32"}, 64'(bus32.out_imm),     imm32);
        check_output({name, ".fmt32"}, 64'(bus32.out_fmt),     64'(fmt32));
        check_output({name, ".ill32"}, 64'(bus32.out_illegal), 64'(ill32));
        check_output({name, ".v64"},   64'(bus64.out_valid),   64'(v));
        check_output({name, ".tag64"}, 64'(bus64.out_tag),     64'(tag));
        check_output({name, ".imm64"}, bus64.out_imm,          imm64);
        check_output({name, ".fmt64"}, 64'(bus64.out_fmt),     64'(fmt64));
        check_output({name, ".ill64"}, 64'(bus64.out_illegal), 64'(ill64));
    endtask

    // Check handshake flags on both instances.
    task automatic check_flow(input string name, input logic v, input logic rdy);
        check_output({name, ".v32"},   64'(bus32.out_valid), 64'(v));
        check_output({name, ".rdy32"}, 64'(bus32.in_ready),  64'(rdy));
        check_output({name, ".v64"},   64'(bus64.out_valid), 64'(v));
        check_output({name, ".rdy64"}, 64'(bus64.in_ready),  64'(rdy));
    endtask

    // Check the full reset state on both instances.
    task automatic check_reset(input string name);
        check_flow(name, 1'b0, 1'b1);
        check_output({name, ".imm32"}, 64'(bus32.out_imm),     64'h0);
        check_output({name, ".fmt32"}, 64'(bus32.out_fmt),     64'd7);
        check_output({name, ".ill32"}, 64'(bus32.out_illegal), 64'h0);
        check_output({name, ".tag32"}, 64'(bus32.out_tag),     64'h0);
        check_output({name, ".imm64"}, bus64.out_imm,          64'h0);
        check_output({name, ".fmt64"}, 64'(bus64.out_fmt),     64'd7);
        check_output({name, ".ill64"}, 64'(bus64.out_illegal), 64'h0);
        check_output({name, ".tag64"}, 64'(bus64.out_tag),     64'h0);
    endtask

    // Present one instruction with out_ready high and check it one cycle later.
    task automatic run_vec(input string name, input logic [31:0] inst, input logic [31:0] tag,
                           input logic [63:0] imm32, input logic [2:0] fmt32, input logic ill32,
                           input logic [63:0] imm64, input logic [2:0] fmt64, input logic ill64);
        apply_stimulus(1'b1, inst, tag, 1'b1);
        @(negedge clk);
        check_both(name, 1'b1, tag, imm32, fmt32, ill32, imm64, fmt64, ill64);
        check_flow({name, ".flow"}, 1'b1, 1'b1);
    endtask

    // Directed sequence: reset, decode vectors back-to-back, backpressure, flush, async reset.
    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        run_vec("beq",    32'hFE000EE3, 32'd10, 64'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
        run_vec("srai_a", 32'h4030D093, 32'd11, 64'h3,        3'd6, 1'b0, 64'h3,                3'd6, 1'b0);
        run_vec("srai_b", 32'h4230D093, 32'd12, 64'h3,        3'd6, 1'b0, 64'h23,               3'd6, 1'b0);
        run_vec("lui",    32'h800000B7, 32'd13, 64'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
        run_vec("csr",    32'h80002073, 32'd14, 64'h800,      3'd1, 1'b0, 64'h800,              3'd1, 1'b0);
        run_vec("bad7f",  32'h0000007F, 32'd15, 64'h0,        3'd7, 1'b1, 64'h0,                3'd7, 1'b1);
        run_vec("opi32",  32'h0000001B, 32'd16, 64'h0,        3'd7, 1'b1, 64'h0,                3'd1, 1'b0);
        run_vec("sw",     32'hFE20AC23, 32'd17, 64'hFFFFFFF8, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0);
        run_vec("jal",    32'h0080006F, 32'd18, 64'h8,        3'd5, 1'b0, 64'h8,                3'd5, 1'b0);
        run_vec("lw",     32'hFFF02083, 32'd19, 64'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        run_vec("add",    32'h00B50533, 32'd20, 64'h0,        3'd0, 1'b0, 64'h0,                3'd0, 1'b0);
        run_vec("op32",   32'h0000003B, 32'd21, 64'h0,        3'd7, 1'b1, 64'h0,                3'd0, 1'b0);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        check_flow("drain", 1'b0, 1'b1);

        // Backpressure: tags 1,2 fill the buffer, tag 3 waits upstream.
        apply_stimulus(1'b1, 32'hFFF02083, 32'd1, 1'b0);
        @(negedge clk);
        check_flow("bp_one", 1'b1, 1'b1);
        check_output("bp_one.tag", 64'(bus32.out_tag), 64'd1);
        apply_stimulus(1'b1, 32'hFFF02083, 32'd2, 1'b0);
        @(negedge clk);
        check_flow("bp_two", 1'b1, 1'b0);
        check_output("bp_two.tag", 64'(bus32.out_tag), 64'd1);
        apply_stimulus(1'b1, 32'hFFF02083, 32'd3, 1'b0);
        @(negedge clk);
        check_flow("bp_hold", 1'b1, 1'b0);
        check_output("bp_hold.tag32", 64'(bus32.out_tag), 64'd1);
        check_output("bp_hold.tag64", 64'(bus64.out_tag), 64'd1);
        apply_stimulus(1'b1, 32'hFFF02083, 32'd3, 1'b1);
        @(negedge clk);
        check_both("bp_pop2", 1'b1, 32'd2, 64'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        check_flow("bp_pop2.flow", 1'b1, 1'b1);
        @(negedge clk);
        check_output("bp_pop3.tag32", 64'(bus32.out_tag), 64'd3);
        check_output("bp_pop3.tag64", 64'(bus64.out_tag), 64'd3);
        check_flow("bp_pop3.flow", 1'b1, 1'b1);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        check_flow("bp_empty", 1'b0, 1'b1);

        // Flush while full, with a same-cycle input that must be dropped.
        apply_stimulus(1'b1, 32'h0080006F, 32'd4, 1'b0);
        @(negedge clk);
        apply_stimulus(1'b1, 32'h0080006F, 32'd5, 1'b0);
        @(negedge clk);
        check_flow("fl_two", 1'b1, 1'b0);
        flush = 1'b1;
        apply_stimulus(1'b1, 32'h0080006F, 32'd6, 1'b0);
        @(negedge clk);
        check_flow("fl_after", 1'b0, 1'b1);
        flush = 1'b0;
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        check_flow("fl_dropped", 1'b0, 1'b1);

        // Asynchronous reset with both entries full, checked before the next edge.
        apply_stimulus(1'b1, 32'h800000B7, 32'd7, 1'b0);
        @(negedge clk);
        apply_stimulus(1'b1, 32'h800000B7, 32'd8, 1'b0);
        @(negedge clk);
        check_flow("rs_two", 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        #1;
        check_reset("async_rst");
        @(negedge clk);
        rst = 1'b0;
        run_vec("post_rst", 32'h0080006F, 32'd9, 64'h8, 3'd5, 1'b0, 64'h8, 3'd5, 1'b0);
        apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
